// File: rtl/dense_pkg.sv
// Constants and helpers shared by the Dense controller and the argmax classifier.
package dense_pkg;

   localparam int DENSE_OUT_COUNT = 10;
   localparam int DENSE_DATA_SIZE = 16;

   // Address width for an n-entry buffer; never narrower than one bit.
   function automatic int clogb2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      OUT  = 2'd2
   } argmax_state_t;

endpackage

// File: rtl/dense_argmax.sv
// Argmax over the Dense output buffer, result offered on a valid/ready handshake.
// Optional ARGMAX_SCORE_EN adds the class_score port carrying the winning score.
module dense_argmax
   import dense_pkg::*;
#(
   parameter int  IN_COUNT  = DENSE_OUT_COUNT,
   parameter int  DATA_SIZE = DENSE_DATA_SIZE,
   localparam int AW        = clogb2(IN_COUNT)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [AW-1:0]        bufferIn_adr,
   input  logic [DATA_SIZE-1:0] bufferIn_data,
   output logic [AW-1:0]        class_idx,
   output logic                 class_valid,
`ifdef ARGMAX_SCORE_EN
   output logic [DATA_SIZE-1:0] class_score,
`endif
   input  logic                 class_ready
);

   localparam logic [AW-1:0] LAST = AW'(IN_COUNT - 1);

   argmax_state_t          state, state_nxt;
   logic [AW-1:0]          cnt;
   logic [DATA_SIZE-1:0]   max_q;
   logic                   take;

   // A start landing on the done cycle is dropped so every done is followed
   // by at least one idle cycle before the next scan.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && !done)            state_nxt = SCAN;
         SCAN:    if (cnt == LAST)               state_nxt = OUT;
         OUT:     if (class_valid && class_ready) state_nxt = IDLE;
         default:                                state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bufferIn_adr = '0;
      if (state == SCAN) bufferIn_adr = cnt;
   end

   // First entry seeds the running max; later entries win only when strictly larger.
   assign take = (cnt == '0) || ($signed(bufferIn_data) > $signed(max_q));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         class_valid <= 1'b0;
         class_idx   <= '0;
         cnt         <= '0;
         max_q       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start && !done) begin
               cnt  <= '0;
               busy <= 1'b1;
            end
            SCAN: begin
               if (take) begin
                  max_q     <= bufferIn_data;
                  class_idx <= cnt;
               end
               if (cnt == LAST) class_valid <= 1'b1;
               else             cnt         <= cnt + 1'b1;
            end
            OUT: if (class_ready) begin
               class_valid <= 1'b0;
               busy        <= 1'b0;
               done        <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef ARGMAX_SCORE_EN
   assign class_score = max_q;
`endif

endmodule

// File: tb/tb_dense_argmax.sv
// Randomized bench for dense_argmax: a 10-entry instance and a 1-entry instance
// checked against an array-based argmax reference.
module tb_dense_argmax;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // 10-entry instance
   logic               start, busy, done, class_valid, class_ready;
   logic [3:0]         adr, class_idx;
   logic [15:0]        data;
   logic signed [15:0] mem [10];
   assign data = (adr < 4'd10) ? mem[adr] : 16'hxxxx;
`ifdef ARGMAX_SCORE_EN
   logic [15:0]        class_score;
`endif

   dense_argmax #(.IN_COUNT(10), .DATA_SIZE(16)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .bufferIn_adr(adr), .bufferIn_data(data), .class_idx(class_idx),
      .class_valid(class_valid),
`ifdef ARGMAX_SCORE_EN
      .class_score(class_score),
`endif
      .class_ready(class_ready));

   // 1-entry instance
   logic        start1, busy1, done1, valid1, ready1;
   logic [0:0]  adr1, idx1;
   logic [15:0] data1;
`ifdef ARGMAX_SCORE_EN
   logic [15:0] score1;
`endif

   dense_argmax #(.IN_COUNT(1), .DATA_SIZE(16)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
      .bufferIn_adr(adr1), .bufferIn_data(data1), .class_idx(idx1),
      .class_valid(valid1),
`ifdef ARGMAX_SCORE_EN
      .class_score(score1),
`endif
      .class_ready(ready1));

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   always @(negedge clk) if (done) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int ref_argmax();
      int best = 0;
      for (int i = 1; i < 10; i++) if (mem[i] > mem[best]) best = i;
      return best;
   endfunction

   task automatic fill_rand(input int range);
      for (int i = 0; i < 10; i++)
         mem[i] = (range == 0) ? 16'($urandom) : 16'($signed($urandom_range(2 * range)) - range);
   endtask

   task automatic run0(input string tag, input int rdy_wait, input bit extra_start);
      int cyc, exp_idx, d0;
      exp_idx = ref_argmax();
      d0 = done_cnt;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      cyc = 0;
      while (!class_valid && cyc < 50) begin
         if (cyc < 10) chk({tag, ".adr"}, 32'(adr), 32'(cyc));
         start = extra_start && (cyc == 3);
         @(negedge clk); cyc++;
      end
      start = 1'b0;
      // edges counted after the one that accepted start
      chk({tag, ".latency"}, 32'(cyc), 32'd10);
      chk({tag, ".idx"}, 32'(class_idx), 32'(exp_idx));
`ifdef ARGMAX_SCORE_EN
      chk({tag, ".score"}, 32'(class_score), 32'(16'(mem[exp_idx])));
`endif
      for (int w = 0; w < rdy_wait; w++) begin
         start = extra_start && (w == 1);
         @(negedge clk);
         chk({tag, ".hold_valid"}, 32'(class_valid), 32'd1);
         chk({tag, ".hold_idx"}, 32'(class_idx), 32'(exp_idx));
      end
      start = 1'b0;
      class_ready = 1'b1;
      @(negedge clk); class_ready = 1'b0;
      chk({tag, ".done"}, 32'(done), 32'd1);
      chk({tag, ".busy_end"}, 32'(busy), 32'd0);
      chk({tag, ".valid_end"}, 32'(class_valid), 32'd0);
      @(negedge clk); #1;
      chk({tag, ".done_pulse"}, 32'(done), 32'd0);
      chk({tag, ".done_cnt"}, 32'(done_cnt), 32'(d0 + 1));
      chk({tag, ".idle"}, 32'(busy), 32'd0);
   endtask

   task automatic run1(input string tag, input logic [15:0] v);
      int cyc;
      data1 = v;
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      cyc = 0;
      while (!valid1 && cyc < 20) begin @(negedge clk); cyc++; end
      chk({tag, ".latency"}, 32'(cyc), 32'd1);
      chk({tag, ".idx"}, 32'(idx1), 32'd0);
`ifdef ARGMAX_SCORE_EN
      chk({tag, ".score"}, 32'(score1), 32'(v));
`endif
      ready1 = 1'b1;
      @(negedge clk); ready1 = 1'b0;
      chk({tag, ".done"}, 32'(done1), 32'd1);
      chk({tag, ".busy"}, 32'(busy1), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      int cyc, d0;
      logic signed [15:0] neg [10];
      start = 0; class_ready = 0; start1 = 0; ready1 = 0; data1 = '0;
      for (int i = 0; i < 10; i++) mem[i] = '0;

      #3 rst = 1'b0;
      #4;
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.valid", 32'(class_valid), 32'd0);
      chk("rst.idx", 32'(class_idx), 32'd0);
      chk("rst.adr", 32'(adr), 32'd0);
      @(negedge clk); @(negedge clk); rst = 1'b1;

      // fixed vector: tie between entries 2 and 6 keeps 2
      mem = '{16'sd3, -16'sd1, 16'sd7, 16'sd2, 16'sd0, 16'sd5, 16'sd7, 16'sd1, -16'sd8, 16'sd4};
      chk("t1.ref", 32'(ref_argmax()), 32'd2);
      run0("t1", 0, 1'b0);

      for (int i = 0; i < 10; i++) mem[i] = -16'sd32768;
      run0("t2a", 0, 1'b0);
      neg = '{-16'sd5, -16'sd3, -16'sd9, -16'sd7, -16'sd6, -16'sd8, -16'sd10, -16'sd12, -16'sd11, -16'sd4};
      mem = neg;
      run0("t2b", 1, 1'b0);

      fill_rand(0);
      run0("t3", 20, 1'b0);

      fill_rand(0);
      run0("t4", 4, 1'b1);

      // reset while scanning at cnt=4
      mem = '{16'sd1, 16'sd50, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd9};
      d0 = done_cnt;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 0;
      while (adr != 4'd4 && cyc < 30) begin @(negedge clk); cyc++; end
      chk("t5.reach", 32'(adr), 32'd4);
      #2 rst = 1'b0;
      #1;
      chk("t5.busy", 32'(busy), 32'd0);
      chk("t5.valid", 32'(class_valid), 32'd0);
      chk("t5.idx", 32'(class_idx), 32'd0);
      chk("t5.adr", 32'(adr), 32'd0);
      chk("t5.done", 32'(done), 32'd0);
      @(negedge clk); rst = 1'b1;
      repeat (15) @(negedge clk);
      chk("t5.no_done", 32'(done_cnt), 32'(d0));
      chk("t5.idle_valid", 32'(class_valid), 32'd0);
      fill_rand(0);
      run0("t5b", 2, 1'b0);

      // narrow value range provokes ties
      for (int r = 0; r < 10; r++) begin
         fill_rand((r % 2 == 0) ? 3 : 0);
         run0("rnd", int'($urandom_range(3)), r[0]);
      end

      run1("t6a", 16'h8000);
      run1("t6b", 16'($urandom));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
